wb_stage_param: RTL and testbench
=================================

Name: wb_stage_param

Overview:
Parametrised MIPS write-back stage. It contains the MEM/WB pipeline register with stall and flush, and it extracts and extends load data by byte lane (lb/lbu/lh/lhu/lw, either endianness). It detects misaligned loads, suppresses writes to $0, and counts retired instructions. It sits between the data-memory stage and the register-file write port.

Parameters:
REG_AW, 5, register address width
PC_W, 30, width of word PC (PC[31:2])
CNT_W, 32, retire counter width
BIG_ENDIAN, 0, 0 = byte k at dout[8k+7:8k]; 1 = byte k at dout[31-8k:24-8k]

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
stall  in  1  hold the stage register
flush  in  1  load a bubble on the next edge
in_valid  in  1  MEM stage holds a real instruction
in_op  in  6  opcode
in_reg  in  REG_AW  destination register
in_regwr  in  1  RegWr
in_memtoreg  in  1  MemtoReg
in_alure  in  32  ALU result / effective address
in_dout  in  32  data-memory word
in_busB  in  32  old rt value (used only for lwl/lwr)
in_pc  in  PC_W  instruction PC
wr_valid  out  1  stage holds a real instruction
wr_reg  out  REG_AW  write address
wr_regwr  out  1  qualified write enable
wr_busW  out  32  write data
wr_pc  out  PC_W  PC of the instruction in the stage
misalign_exc  out  1  misaligned load in the stage
retire_cnt  out  CNT_W  retired-instruction count

Behaviour:
- Stage register: on each rising edge, priority is rst > flush > stall > load.
  - rst: all stage fields 0, retire_cnt 0.
  - flush: valid <= 0; other fields don't-care, but regwr is forced to 0. Flush wins over stall.
  - stall: all fields hold.
  - Otherwise: latch all in_* fields.
- Outputs are combinational from the stage register, so latency is 1 cycle from inputs to wr_*.
- Reset values of the outputs follow from the zeroed stage register: wr_valid, wr_regwr and misalign_exc are 0, wr_busW is 0, wr_reg is 0, wr_pc is 0.
- Address bits: k = alure[1:0]. Lane index L = k, or 3-k when BIG_ENDIAN=1.
- wr_busW by opcode:
  - 100000 lb: sign-extended byte L.
  - 100100 lbu: zero-extended byte L.
  - 100001 lh: sign-extended halfword at lane L[1] (bits 16*L[1]+15 down to 16*L[1]).
  - 100101 lhu: same halfword, zero-extended.
  - 100011 lw: the full dout word.
  - Any other opcode: memtoreg ? dout : alure.
- misalign_exc = valid & ((lh|lhu) & k[0] | lw & (k != 0)).
- wr_regwr = valid & regwr & (reg != 0) & ~misalign_exc.
- retire_cnt increments by 1 on an edge where valid=1, misalign_exc=0, stall=0, flush=0 and rst=0. It wraps from 2^CNT_W-1 to 0.
- While the stage is stalled, wr_regwr stays asserted with unchanged data. The register-file write is idempotent, so the instruction is still counted only once.
- Simultaneous stall and flush: flush wins, and the held instruction is discarded without being counted.
- rst mid-stall clears everything on that edge.

Optional Feature:
WB_LWLR_EN
- Defined: 100010 lwl and 100110 lwr merge data with in_busB, which is latched as a stage field. Let n = L.
  - lwl: busW = (dout << 8*(3-n)) | (busB & ((1 << 8*(3-n)) - 1)).
  - lwr: busW = (dout >> 8*n) | (busB & ~(32'hFFFFFFFF >> 8*n)).
  - Neither raises misalign_exc.
- Undefined: in_busB is ignored and not latched, and both opcodes take the default memtoreg/alure path.

Test Plan:
- Reset then idle: rst=1 for one cycle, then in_valid=0 -> all outputs 0, retire_cnt=0 for 5 cycles.
- Byte loads, BIG_ENDIAN=0, dout=0x8344_A57F, regwr=1, reg=8:
  - lb, alure=...01 -> busW=0xFFFF_FFA5.
  - lbu, alure=...03 -> busW=0x0000_0083.
  - Each result appears 1 cycle after the input; retire_cnt 0->2.
- Halfword/word checks:
  - lh, alure=...02, dout=0x8001_1234 -> busW=0xFFFF_8001.
  - lw, alure=...02 -> misalign_exc=1, wr_regwr=0, counter unchanged.
- Stall then flush:
  - Load an ALU op (alure=0x55, memtoreg=0, reg=3), then hold stall=1 for 3 cycles -> outputs stable, count +1 only after release.
  - Repeat with stall=1 and flush=1 together -> wr_valid=0, no count.
- Write to $0: reg=0, regwr=1 -> wr_regwr=0, retire_cnt still +1.
- Counter wrap, with CNT_W=4: 17 retirements -> retire_cnt=1.
- WB_LWLR_EN defined: lwl, alure=...01, dout=0xAABBCCDD, busB=0x11223344 -> busW=0xCCDD3344.

Source files
------------

// File: rtl/wb_stage_param.sv
// ---------------------------------------------------------------------------------------------
// wb_stage_param -- MIPS write-back stage
//
// Holds the MEM/WB pipeline register. It supports stall and flush, and it turns the
// registered memory word into register-file write data. Byte and halfword loads are
// extracted by lane and then sign- or zero-extended. Misaligned halfword/word loads are
// flagged and their write is suppressed. Writes to $0 are dropped. Instructions that
// leave the stage cleanly are counted.
//
// Optional build macro:
//   WB_LWLR_EN  adds lwl/lwr. These merge the memory word with the old rt value (in_busB),
//               which is then latched as a stage field. When the macro is undefined,
//               in_busB is ignored and lwl/lwr take the generic memtoreg/alure path.
//
// Parameters:
//   REG_AW      register address width
//   PC_W        word PC width (PC[31:2])
//   CNT_W       retire counter width
//   BIG_ENDIAN  0: byte k at dout[8k+7:8k]; 1: byte k at dout[31-8k:24-8k]
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   stall, flush      hold the stage / load a bubble (flush wins over stall)
//   in_*              MEM-stage instruction fields
//   wr_valid          stage holds a real instruction
//   wr_reg/wr_regwr   register-file write address / qualified write enable
//   wr_busW           register-file write data
//   wr_pc             PC of the instruction in the stage
//   misalign_exc      misaligned load in the stage
//   retire_cnt        retired-instruction count (wraps)
// ---------------------------------------------------------------------------------------------
module wb_stage_param #(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned PC_W       = 30,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned BIG_ENDIAN = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [5:0]        in_op,
    input  logic [REG_AW-1:0] in_reg,
    input  logic              in_regwr,
    input  logic              in_memtoreg,
    input  logic [31:0]       in_alure,
    input  logic [31:0]       in_dout,
    input  logic [31:0]       in_busB,
    input  logic [PC_W-1:0]   in_pc,
    output logic              wr_valid,
    output logic [REG_AW-1:0] wr_reg,
    output logic              wr_regwr,
    output logic [31:0]       wr_busW,
    output logic [PC_W-1:0]   wr_pc,
    output logic              misalign_exc,
    output logic [CNT_W-1:0]  retire_cnt
);

    // Load opcodes decoded in this stage
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
`ifdef WB_LWLR_EN
    localparam logic [5:0] OP_LWL = 6'b100010;
    localparam logic [5:0] OP_LWR = 6'b100110;
`endif

    // -----------------------------------------------------------------------------------------
    // MEM/WB stage register
    // -----------------------------------------------------------------------------------------
    logic              r_valid;
    logic [5:0]        r_op;
    logic [REG_AW-1:0] r_reg;
    logic              r_regwr;
    logic              r_memtoreg;
    logic [31:0]       r_alure;
    logic [31:0]       r_dout;
    logic [PC_W-1:0]   r_pc;
    logic [CNT_W-1:0]  r_cnt;
`ifdef WB_LWLR_EN
    logic [31:0]       r_busB;
`endif

    logic              w_misalign;
    logic              w_retire;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_op       <= '0;
            r_reg      <= '0;
            r_regwr    <= 1'b0;
            r_memtoreg <= 1'b0;
            r_alure    <= '0;
            r_dout     <= '0;
            r_pc       <= '0;
        end else if (flush) begin
            // The remaining fields are don't-care in a bubble; holding them avoids toggling.
            r_valid <= 1'b0;
            r_regwr <= 1'b0;
        end else if (!stall) begin
            r_valid    <= in_valid;
            r_op       <= in_op;
            r_reg      <= in_reg;
            r_regwr    <= in_regwr;
            r_memtoreg <= in_memtoreg;
            r_alure    <= in_alure;
            r_dout     <= in_dout;
            r_pc       <= in_pc;
        end
    end

`ifdef WB_LWLR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busB <= '0;
        end else if (!flush && !stall) begin
            r_busB <= in_busB;
        end
    end
`else
    logic w_unused_busb;
    assign w_unused_busb = ^in_busB;
`endif

    // An instruction retires when it leaves the stage cleanly. A stalled instruction keeps
    // writing the same value, but it is counted only on the edge that releases it.
    assign w_retire = r_valid & ~w_misalign & ~stall & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_retire) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // -----------------------------------------------------------------------------------------
    // Lane selection and load extension
    // -----------------------------------------------------------------------------------------
    logic [1:0]  w_k;
    logic [1:0]  w_lane;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_is_half;
    logic        w_is_word;
    logic [31:0] w_busw;

    assign w_k = r_alure[1:0];
    // 3-k is the bitwise inverse of a 2-bit k
    assign w_lane = (BIG_ENDIAN != 0) ? ~w_k : w_k;

    assign w_byte = r_dout[{w_lane, 3'b000} +: 8];
    assign w_half = r_dout[{w_lane[1], 4'b0000} +: 16];

    assign w_is_half = (r_op == OP_LH) || (r_op == OP_LHU);
    assign w_is_word = (r_op == OP_LW);

    assign w_misalign = r_valid & ((w_is_half & w_k[0]) | (w_is_word & (w_k != 2'b00)));

`ifdef WB_LWLR_EN
    // lwl keeps the low 8*(3-n) bits of rt; lwr keeps the high 8*n bits of rt
    logic [4:0]  w_lwl_sh;
    logic [4:0]  w_lwr_sh;
    logic [31:0] w_lwl_mask;
    logic [31:0] w_lwr_mask;
    logic [31:0] w_lwl_data;
    logic [31:0] w_lwr_data;

    assign w_lwl_sh   = {~w_lane, 3'b000};
    assign w_lwr_sh   = {w_lane, 3'b000};
    assign w_lwl_mask = (32'd1 << w_lwl_sh) - 32'd1;
    assign w_lwr_mask = ~(32'hFFFF_FFFF >> w_lwr_sh);
    assign w_lwl_data = (r_dout << w_lwl_sh) | (r_busB & w_lwl_mask);
    assign w_lwr_data = (r_dout >> w_lwr_sh) | (r_busB & w_lwr_mask);
`endif

    always_comb begin
        w_busw = r_memtoreg ? r_dout : r_alure;
        case (r_op)
            OP_LB:   w_busw = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_busw = {24'd0, w_byte};
            OP_LH:   w_busw = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_busw = {16'd0, w_half};
            OP_LW:   w_busw = r_dout;
`ifdef WB_LWLR_EN
            OP_LWL:  w_busw = w_lwl_data;
            OP_LWR:  w_busw = w_lwr_data;
`endif
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------------------------
    assign wr_valid     = r_valid;
    assign wr_reg       = r_reg;
    assign wr_pc        = r_pc;
    assign wr_busW      = w_busw;
    assign misalign_exc = w_misalign;
    // $0 is hard-wired to zero, so writes to it are dropped
    assign wr_regwr     = r_valid & r_regwr & (r_reg != '0) & ~w_misalign;
    assign retire_cnt   = r_cnt;

endmodule

// File: tb/tb_wb_stage_param.sv
// Directed bench for wb_stage_param. One little-endian instance with default parameters
// and one big-endian instance with a 4-bit counter share all inputs.
module tb_wb_stage_param;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        in_valid, in_regwr, in_memtoreg;
    logic [5:0]  in_op;
    logic [4:0]  in_reg;
    logic [31:0] in_alure, in_dout, in_busB;
    logic [29:0] in_pc;

    logic        le_valid, le_regwr, le_misalign;
    logic [4:0]  le_reg;
    logic [31:0] le_busw, le_cnt;
    logic [29:0] le_pc;

    logic        be_valid, be_regwr, be_misalign;
    logic [4:0]  be_reg;
    logic [31:0] be_busw;
    logic [3:0]  be_cnt;
    logic [29:0] be_pc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_stage_param u_dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_op        (in_op),
        .in_reg       (in_reg),
        .in_regwr     (in_regwr),
        .in_memtoreg  (in_memtoreg),
        .in_alure     (in_alure),
        .in_dout      (in_dout),
        .in_busB      (in_busB),
        .in_pc        (in_pc),
        .wr_valid     (le_valid),
        .wr_reg       (le_reg),
        .wr_regwr     (le_regwr),
        .wr_busW      (le_busw),
        .wr_pc        (le_pc),
        .misalign_exc (le_misalign),
        .retire_cnt   (le_cnt)
    );

    wb_stage_param #(
        .CNT_W      (4),
        .BIG_ENDIAN (1)
    ) u_dut_be (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_op        (in_op),
        .in_reg       (in_reg),
        .in_regwr     (in_regwr),
        .in_memtoreg  (in_memtoreg),
        .in_alure     (in_alure),
        .in_dout      (in_dout),
        .in_busB      (in_busB),
        .in_pc        (in_pc),
        .wr_valid     (be_valid),
        .wr_reg       (be_reg),
        .wr_regwr     (be_regwr),
        .wr_busW      (be_busw),
        .wr_pc        (be_pc),
        .misalign_exc (be_misalign),
        .retire_cnt   (be_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rd,
                         input logic rw, input logic m2r, input logic [31:0] alu,
                         input logic [31:0] dout, input logic [29:0] pc);
        in_valid    = v;
        in_op       = op;
        in_reg      = rd;
        in_regwr    = rw;
        in_memtoreg = m2r;
        in_alure    = alu;
        in_dout     = dout;
        in_pc       = pc;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; in_busB = 32'h0;
        drive(1'b1, 6'b100011, 5'd7, 1'b1, 1'b1, 32'h1234, 32'hFFFF_FFFF, 30'h3);
        tick();
        rst = 1'b0;
        drive(1'b0, 6'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 30'h0);
        check("rst_valid", {31'd0, le_valid}, 32'd0);
        check("rst_busw", le_busw, 32'd0);
        check("rst_reg", {27'd0, le_reg}, 32'd0);
        check("rst_pc", {2'd0, le_pc}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_valid", {31'd0, le_valid}, 32'd0);
            check("idle_regwr", {31'd0, le_regwr}, 32'd0);
            check("idle_misalign", {31'd0, le_misalign}, 32'd0);
            check("idle_cnt", le_cnt, 32'd0);
        end

        // Byte loads
        drive(1'b1, 6'b100000, 5'd8, 1'b1, 1'b1, 32'h1001, 32'h8344_A57F, 30'h100);
        tick();
        check("lb_busw", le_busw, 32'hFFFF_FFA5);
        check("lb_be_busw", be_busw, 32'h0000_0044);
        check("lb_regwr", {31'd0, le_regwr}, 32'd1);
        check("lb_reg", {27'd0, le_reg}, 32'd8);
        check("lb_pc", {2'd0, le_pc}, 32'h100);
        check("lb_cnt", le_cnt, 32'd0);
        drive(1'b1, 6'b100100, 5'd8, 1'b1, 1'b1, 32'h1003, 32'h8344_A57F, 30'h101);
        tick();
        check("lbu_busw", le_busw, 32'h0000_0083);
        check("lbu_be_busw", be_busw, 32'h0000_007F);
        check("lbu_cnt", le_cnt, 32'd1);

        // Halfword, then misaligned word
        drive(1'b1, 6'b100001, 5'd8, 1'b1, 1'b1, 32'h1002, 32'h8001_1234, 30'h102);
        tick();
        check("lh_busw", le_busw, 32'hFFFF_8001);
        check("lh_be_busw", be_busw, 32'h0000_1234);
        check("lh_misalign", {31'd0, le_misalign}, 32'd0);
        check("lh_cnt", le_cnt, 32'd2);
        drive(1'b1, 6'b100011, 5'd8, 1'b1, 1'b1, 32'h1002, 32'h8001_1234, 30'h103);
        tick();
        check("lw_misalign", {31'd0, le_misalign}, 32'd1);
        check("lw_regwr", {31'd0, le_regwr}, 32'd0);
        check("lw_cnt", le_cnt, 32'd3);
        drive(1'b0, 6'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 30'h0);
        tick();
        check("lw_no_count", le_cnt, 32'd3);

        // ALU op held by stall
        drive(1'b1, 6'b000000, 5'd3, 1'b1, 1'b0, 32'h55, 32'hDEAD_BEEF, 30'h200);
        tick();
        check("alu_busw", le_busw, 32'h55);
        check("alu_regwr", {31'd0, le_regwr}, 32'd1);
        stall = 1'b1;
        drive(1'b1, 6'b000000, 5'd5, 1'b1, 1'b0, 32'h99, 32'h0, 30'h201);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_busw", le_busw, 32'h55);
            check("stall_reg", {27'd0, le_reg}, 32'd3);
            check("stall_regwr", {31'd0, le_regwr}, 32'd1);
            check("stall_cnt", le_cnt, 32'd3);
        end
        stall = 1'b0;
        drive(1'b0, 6'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 30'h0);
        tick();
        check("release_cnt", le_cnt, 32'd4);
        check("release_valid", {31'd0, le_valid}, 32'd0);

        // Stall and flush together: flush wins, nothing counted
        drive(1'b1, 6'b000000, 5'd4, 1'b1, 1'b0, 32'h66, 32'h0, 30'h210);
        tick();
        check("alu2_busw", le_busw, 32'h66);
        stall = 1'b1; flush = 1'b1;
        tick();
        check("flush_valid", {31'd0, le_valid}, 32'd0);
        check("flush_regwr", {31'd0, le_regwr}, 32'd0);
        check("flush_cnt", le_cnt, 32'd4);
        stall = 1'b0; flush = 1'b0;
        drive(1'b0, 6'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 30'h0);
        tick();
        check("post_flush_cnt", le_cnt, 32'd4);

        // Write to $0 is dropped but still retires
        drive(1'b1, 6'b000000, 5'd0, 1'b1, 1'b0, 32'h77, 32'h0, 30'h220);
        tick();
        check("r0_regwr", {31'd0, le_regwr}, 32'd0);
        check("r0_valid", {31'd0, le_valid}, 32'd1);
        drive(1'b0, 6'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 30'h0);
        tick();
        check("r0_cnt", le_cnt, 32'd5);

        // Reset during a stall clears everything
        drive(1'b1, 6'b000000, 5'd6, 1'b1, 1'b0, 32'h88, 32'h0, 30'h230);
        tick();
        stall = 1'b1; rst = 1'b1;
        tick();
        check("rst_stall_valid", {31'd0, le_valid}, 32'd0);
        check("rst_stall_busw", le_busw, 32'd0);
        check("rst_stall_cnt", le_cnt, 32'd0);
        check("rst_stall_be_cnt", {28'd0, be_cnt}, 32'd0);
        stall = 1'b0; rst = 1'b0;

        // 17 retirements: the 4-bit counter wraps to 1
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 6'b000000, 5'd1, 1'b1, 1'b0, i, 32'h0, 30'(i));
            tick();
        end
        drive(1'b0, 6'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 30'h0);
        tick();
        check("wrap_cnt32", le_cnt, 32'd17);
        check("wrap_cnt4", {28'd0, be_cnt}, 32'd1);

        // lwl / lwr
        in_busB = 32'h1122_3344;
        drive(1'b1, 6'b100010, 5'd9, 1'b1, 1'b1, 32'h1001, 32'hAABB_CCDD, 30'h300);
        tick();
`ifdef WB_LWLR_EN
        check("lwl_busw", le_busw, 32'hCCDD_3344);
        check("lwl_be_busw", be_busw, 32'hBBCC_DD44);
`else
        check("lwl_busw", le_busw, 32'hAABB_CCDD);
        check("lwl_be_busw", be_busw, 32'hAABB_CCDD);
`endif
        check("lwl_misalign", {31'd0, le_misalign}, 32'd0);
        drive(1'b1, 6'b100110, 5'd9, 1'b1, 1'b1, 32'h1001, 32'hAABB_CCDD, 30'h301);
        tick();
`ifdef WB_LWLR_EN
        check("lwr_busw", le_busw, 32'h11AA_BBCC);
        check("lwr_be_busw", be_busw, 32'h1122_AABB);
`else
        check("lwr_busw", le_busw, 32'hAABB_CCDD);
        check("lwr_be_busw", be_busw, 32'hAABB_CCDD);
`endif
        check("lwr_regwr", {31'd0, le_regwr}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
